// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types, default raster geometry and helpers for video_timing_gen.
package vtg_pkg;

  // Display mode captured at frame boundaries.
  typedef struct packed {
    logic pal;
    logic scandouble;
    logic interlace;
  } vtg_mode_t;

  // Default geometry (320x240 NTSC / 320x288 PAL, 15 kHz).
  localparam int unsigned VTG_H_ACTIVE      = 32'd320;
  localparam int unsigned VTG_H_FP          = 32'd16;
  localparam int unsigned VTG_H_SYNC        = 32'd32;
  localparam int unsigned VTG_H_BP          = 32'd32;
  localparam int unsigned VTG_V_ACTIVE_NTSC = 32'd240;
  localparam int unsigned VTG_V_ACTIVE_PAL  = 32'd288;
  localparam int unsigned VTG_V_FP          = 32'd3;
  localparam int unsigned VTG_V_SYNC        = 32'd3;
  localparam int unsigned VTG_V_BP_NTSC     = 32'd16;
  localparam int unsigned VTG_V_BP_PAL      = 32'd18;
  localparam int unsigned VTG_CE_DIV        = 32'd4;

  localparam int unsigned VTG_H_TOTAL      = VTG_H_ACTIVE + VTG_H_FP + VTG_H_SYNC + VTG_H_BP;
  localparam int unsigned VTG_V_TOTAL_NTSC = VTG_V_ACTIVE_NTSC + VTG_V_FP + VTG_V_SYNC + VTG_V_BP_NTSC;
  localparam int unsigned VTG_V_TOTAL_PAL  = VTG_V_ACTIVE_PAL + VTG_V_FP + VTG_V_SYNC + VTG_V_BP_PAL;

  // Lines in the frame for a mode/field; the odd field carries one extra blank line.
  // The per-standard totals are passed in so parameter overrides of the top stay consistent.
  function automatic logic [15:0] vtg_vtotal(input vtg_mode_t mode, input logic field,
                                             input logic [15:0] vt_ntsc, input logic [15:0] vt_pal);
    logic [15:0] base;
    base = mode.pal ? vt_pal : vt_ntsc;
    return base + {15'd0, field};
  endfunction

endpackage

// File: rtl/vtg_ce_div.sv
// vtg_ce_div: programmable pixel-clock-enable divider with synchronous clear.
// ce_pix is registered; ce_nxt is its next value so the parent can register
// decodes that must line up with ce_pix.
module vtg_ce_div #(
  parameter int unsigned DW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic [DW-1:0] last,
  output logic          ce_pix,
  output logic          ce_nxt
);

  logic [DW-1:0] div_q, div_d;
  logic          ce_q, ce_d;

  // Count 0..last; a pixel enable always ends the count, so a new divide ratio starts from 0.
  always_comb begin
    if (clr || ce_q) begin
      div_d = '0;
    end else begin
      div_d = div_q + DW'(1);
    end
    ce_d = (div_d == last);
  end

  // Divider state and registered enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_pix = ce_q;
  assign ce_nxt = ce_d;

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (pixel enable, position, blanking,
// sync, frame strobe) with NTSC/PAL and 15/31 kHz modes latched at frame end.
// Optional feature: define VTG_INTERLACE_EN for interlaced field timing.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int unsigned H_ACTIVE      = VTG_H_ACTIVE,
  parameter int unsigned H_FP          = VTG_H_FP,
  parameter int unsigned H_SYNC        = VTG_H_SYNC,
  parameter int unsigned H_BP          = VTG_H_BP,
  parameter int unsigned V_ACTIVE_NTSC = VTG_V_ACTIVE_NTSC,
  parameter int unsigned V_ACTIVE_PAL  = VTG_V_ACTIVE_PAL,
  parameter int unsigned V_FP          = VTG_V_FP,
  parameter int unsigned V_SYNC        = VTG_V_SYNC,
  parameter int unsigned V_BP_NTSC     = VTG_V_BP_NTSC,
  parameter int unsigned V_BP_PAL      = VTG_V_BP_PAL,
  parameter int unsigned CE_DIV        = VTG_CE_DIV,
  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL_NTSC = V_ACTIVE_NTSC + V_FP + V_SYNC + V_BP_NTSC,
  localparam int unsigned V_TOTAL_PAL  = V_ACTIVE_PAL + V_FP + V_SYNC + V_BP_PAL,
  localparam int unsigned HW           = $clog2(H_TOTAL),
  localparam int unsigned VW           = $clog2(V_TOTAL_PAL + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pal,
  input  logic          scandouble,
  input  logic          interlace,
  output logic          ce_pix,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          HBlank,
  output logic          VBlank,
  output logic          HSync,
  output logic          VSync,
  output logic          de,
  output logic          frame_start,
  output logic          field
);

  localparam int unsigned DW = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

  vtg_mode_t     mode_in_s, mode_q, mode_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d, vtot_s;
  logic          field_s;
  logic          line_end_s, frame_end_s, latch_s, clr_s;
  logic          ce_pix_s, ce_nxt_s;
  logic [DW-1:0] last_s;
  logic [31:0]   vact_s;
  logic          hblank_q, hblank_d, vblank_q, vblank_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          de_q, de_d, fs_q, fs_d;

  assign mode_in_s.pal        = pal;
  assign mode_in_s.scandouble = scandouble;

`ifdef VTG_INTERLACE_EN
  logic field_q, field_d;

  assign mode_in_s.interlace = interlace;

  // Field toggles per frame only for latched interlaced 15 kHz timing, else parks at 0.
  always_comb begin
    if (latch_s) begin
      field_d = (mode_in_s.interlace && !mode_in_s.scandouble) ? ~field_q : 1'b0;
    end else begin
      field_d = field_q;
    end
  end

  // Field register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      field_q <= 1'b0;
    end else begin
      field_q <= field_d;
    end
  end

  assign field_s = field_q;
`else
  logic unused_interlace_s;

  assign unused_interlace_s  = interlace;
  assign mode_in_s.interlace = 1'b0;
  assign field_s             = 1'b0;
`endif

  // Frame geometry, end-of-line/frame detection and the mode latch point.
  always_comb begin
    vtot_s      = VW'(vtg_vtotal(mode_q, field_s, 16'(V_TOTAL_NTSC), 16'(V_TOTAL_PAL)));
    line_end_s  = (32'(hcount_q) == H_TOTAL - 32'd1);
    frame_end_s = line_end_s && (vcount_q == vtot_s - VW'(1));
    latch_s     = ce_pix_s && frame_end_s;
    clr_s       = latch_s && (mode_in_s.scandouble != mode_q.scandouble);
  end

  // Next raster position and next latched mode.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    mode_d   = mode_q;
    if (ce_pix_s) begin
      if (line_end_s) begin
        hcount_d = '0;
        vcount_d = frame_end_s ? '0 : vcount_q + VW'(1);
      end else begin
        hcount_d = hcount_q + HW'(1);
      end
    end else begin
      hcount_d = hcount_q;
    end
    if (latch_s) begin
      mode_d = mode_in_s;
    end else begin
      mode_d = mode_q;
    end
    last_s = mode_d.scandouble ? DW'(CE_DIV / 2 - 1) : DW'(CE_DIV - 1);
  end

  // Decodes of the next position so they register in step with hcount/vcount.
  always_comb begin
    vact_s   = mode_d.pal ? V_ACTIVE_PAL : V_ACTIVE_NTSC;
    hblank_d = (32'(hcount_d) >= H_ACTIVE);
    vblank_d = (32'(vcount_d) >= vact_s);
    hsync_d  = (32'(hcount_d) >= H_ACTIVE + H_FP) && (32'(hcount_d) < H_ACTIVE + H_FP + H_SYNC);
    vsync_d  = (32'(vcount_d) >= vact_s + V_FP) && (32'(vcount_d) < vact_s + V_FP + V_SYNC);
    de_d     = !(hblank_d || vblank_d);
    fs_d     = ce_nxt_s && (hcount_d == '0) && (vcount_d == '0);
  end

  vtg_ce_div #(
    .DW(DW)
  ) u_ce_div (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr_s),
    .last   (last_s),
    .ce_pix (ce_pix_s),
    .ce_nxt (ce_nxt_s)
  );

  // Position, mode and output registers; mode follows the inputs while in reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q <= '0;
      vcount_q <= '0;
      mode_q   <= mode_in_s;
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      de_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      mode_q   <= mode_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      fs_q     <= fs_d;
    end
  end

  assign ce_pix      = ce_pix_s;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign HBlank      = hblank_q;
  assign VBlank      = vblank_q;
  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign field       = field_s;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench. The stimulus process picks a mode per
// frame, changes the inputs at a random point of the preceding frame and pushes
// the expected raster of the next frame; a monitor pops one entry per ce_pix.
// A second instance at default geometry checks the first full line.
module tb_video_timing_gen;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VAN = 6, VAP = 8, VFP = 1, VS = 2, VBN = 2, VBP = 3;
  localparam int CE = 4;
  localparam int NF = 24;
`ifdef VTG_INTERLACE_EN
  localparam bit IL_EN = 1'b1;
`else
  localparam bit IL_EN = 1'b0;
`endif

  typedef struct {
    int h; int v; bit hb; bit vb; bit hs; bit vs; bit de; bit fs; bit fld; int gap;
  } pix_t;

  logic clk = 1'b0, reset_n = 1'b0;
  logic pal = 1'b0, scandouble = 1'b0, interlace = 1'b0;
  logic ce_pix, HBlank, VBlank, HSync, VSync, de, frame_start, field;
  logic [3:0] hcount, vcount;
  logic d_ce, d_hb, d_vb, d_hs, d_vs, d_de, d_fs, d_fld;
  logic [8:0] d_h, d_v;

  int n_pass = 0, n_chk = 0;
  pix_t exp_q[$];
  int gap_cnt = 1;
  bit stray = 1'b0;
  logic [2:0] md[NF];

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE_NTSC(VAN), .V_ACTIVE_PAL(VAP), .V_FP(VFP), .V_SYNC(VS),
    .V_BP_NTSC(VBN), .V_BP_PAL(VBP), .CE_DIV(CE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pal(pal), .scandouble(scandouble), .interlace(interlace),
    .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount), .HBlank(HBlank), .VBlank(VBlank),
    .HSync(HSync), .VSync(VSync), .de(de), .frame_start(frame_start), .field(field)
  );

  video_timing_gen dut_def (
    .clk(clk), .reset_n(reset_n), .pal(1'b0), .scandouble(1'b0), .interlace(1'b0),
    .ce_pix(d_ce), .hcount(d_h), .vcount(d_v), .HBlank(d_hb), .VBlank(d_vb),
    .HSync(d_hs), .VSync(d_vs), .de(d_de), .frame_start(d_fs), .field(d_fld)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input bit ok, input string nm, input string got, input string want);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", nm, got, want);
  endtask

  function automatic int vtot(input bit p, input bit f);
    return (p ? VAP + VFP + VS + VBP : VAN + VFP + VS + VBN) + (f ? 1 : 0);
  endfunction

  // Modes as {pal, scandouble, interlace}.
  function automatic logic [2:0] dir_mode(input int k);
    case (k)
      1, 2:    return 3'b100;
      3, 4:    return 3'b010;
      5, 6, 7: return 3'b001;
      8:       return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  // Expected raster of one whole frame, straight from the timing rules.
  task automatic push_frame(input logic [2:0] m, input bit f);
    pix_t e;
    int vact;
    vact = m[2] ? VAP : VAN;
    for (int v = 0; v < vtot(m[2], f); v++) begin
      for (int h = 0; h < HT; h++) begin
        e.h   = h;
        e.v   = v;
        e.hb  = (h >= HA);
        e.vb  = (v >= vact);
        e.hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
        e.vs  = (v >= vact + VFP) && (v < vact + VFP + VS);
        e.de  = !(e.hb || e.vb);
        e.fs  = (h == 0) && (v == 0);
        e.fld = f;
        e.gap = m[1] ? CE / 2 : CE;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic chk_reset(input string nm);
    string got;
    got = $sformatf("ce=%0d h=%0d v=%0d hb=%0d vb=%0d hs=%0d vs=%0d de=%0d fs=%0d fld=%0d",
                    ce_pix, hcount, vcount, HBlank, VBlank, HSync, VSync, de, frame_start, field);
    check(got == "ce=0 h=0 v=0 hb=0 vb=0 hs=0 vs=0 de=1 fs=0 fld=0", nm, got,
          "ce=0 h=0 v=0 hb=0 vb=0 hs=0 vs=0 de=1 fs=0 fld=0");
  endtask

  // Monitor: one scoreboard entry per presented pixel, plus divider spacing.
  initial begin : monitor
    pix_t e;
    string got, want;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        gap_cnt = 1;
        stray   = 1'b0;
      end else begin
        gap_cnt++;
        if (ce_pix) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "sb_empty", $sformatf("pixel h=%0d v=%0d", hcount, vcount), "no pixel");
          end else begin
            e = exp_q.pop_front();
            got = $sformatf("h=%0d v=%0d hb=%0d vb=%0d hs=%0d vs=%0d de=%0d fs=%0d fld=%0d gap=%0d x=%0d",
                            hcount, vcount, HBlank, VBlank, HSync, VSync, de, frame_start, field,
                            gap_cnt, stray);
            want = $sformatf("h=%0d v=%0d hb=%0d vb=%0d hs=%0d vs=%0d de=%0d fs=%0d fld=%0d gap=%0d x=0",
                             e.h, e.v, e.hb, e.vb, e.hs, e.vs, e.de, e.fs, e.fld, e.gap);
            check(got == want, "pix", got, want);
          end
          gap_cnt = 0;
          stray   = 1'b0;
        end else if (frame_start) begin
          stray = 1'b1;
        end
      end
    end
  end

  // Default-geometry instance: first line plus wrap into line 1 (line period 1600 clk).
  initial begin : def_check
    int p, g, h;
    string got, want;
    p = 0;
    @(posedge reset_n);
    g = 1;
    repeat (1620) begin
      @(negedge clk);
      g++;
      if (d_ce) begin
        h = p % 400;
        got = $sformatf("h=%0d v=%0d hb=%0d vb=%0d hs=%0d de=%0d fs=%0d gap=%0d",
                        d_h, d_v, d_hb, d_vb, d_hs, d_de, d_fs, g);
        want = $sformatf("h=%0d v=%0d hb=%0d vb=0 hs=%0d de=%0d fs=%0d gap=4",
                         h, p / 400, h >= 320, (h >= 336) && (h < 368), h < 320, p == 0);
        check(got == want, "def_pix", got, want);
        p++;
        g = 0;
      end
    end
  end

  initial begin : stim
    int L, r;
    bit cf, nf;
    for (int k = 0; k < NF; k++) begin
      if (k < 9 || k == NF - 1) md[k] = dir_mode(k);
      else md[k] = 3'($urandom_range(7, 0));
    end
    {pal, scandouble, interlace} = md[0];
    cf = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset_init");
    push_frame(md[0], cf);
    #1 reset_n = 1'b1;

    for (int k = 0; k < NF - 1; k++) begin
      L = vtot(md[k][2], cf) * HT * (md[k][1] ? CE / 2 : CE);
      r = int'($urandom_range(L - 2, 1));
      repeat (r) @(negedge clk);
      {pal, scandouble, interlace} = md[k + 1];
      nf = (IL_EN && md[k + 1][0] && !md[k + 1][1]) ? ~cf : 1'b0;
      push_frame(md[k + 1], nf);
      repeat (L - r) @(negedge clk);
      cf = nf;
    end

    // Last frame is NTSC 15 kHz: reset while at pixel (11,7), inside both syncs.
    repeat (493) @(negedge clk);
    #1;
    check(HSync && VSync && !de, "pre_reset_sync",
          $sformatf("hs=%0d vs=%0d de=%0d", HSync, VSync, de), "hs=1 vs=1 de=0");
    #1 reset_n = 1'b0;
    #1 chk_reset("reset_mid");
    exp_q.delete();
    {pal, scandouble, interlace} = 3'b000;
    push_frame(3'b000, 1'b0);
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    L = vtot(1'b0, 1'b0) * HT * CE;
    repeat (L) @(negedge clk);
    #1;
    check(exp_q.size() == 0, "sb_drain", $sformatf("%0d pixels pending", exp_q.size()),
          "0 pixels pending");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for cores, replacing the fixed NTSC/PAL counter logic inside each core.
- Produces the pixel clock enable, h/v position, blanking, sync and frame strobe.
- Selects NTSC or PAL vertical timing and 15 kHz or scandoubled 31 kHz line rate.
- Mode inputs take effect only at frame boundaries, so the scaler never sees a torn frame.

Parameters:
- H_ACTIVE, 320, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 32, horizontal sync width (pixels)
- H_BP, 32, horizontal back porch (pixels); H_TOTAL = sum = 400
- V_ACTIVE_NTSC, 240, visible lines, NTSC
- V_ACTIVE_PAL, 288, visible lines, PAL
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 3, vertical sync width (lines)
- V_BP_NTSC, 16, back porch, NTSC; V_TOTAL_NTSC = 262
- V_BP_PAL, 18, back porch, PAL; V_TOTAL_PAL = 312
- CE_DIV, 4, clk cycles per pixel at 15 kHz; must be even and >= 2

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- pal  in  1  0 = NTSC, 1 = PAL vertical timing
- scandouble  in  1  1 = pixel rate doubled (divider CE_DIV/2)
- interlace  in  1  interlaced field timing request (used only with VTG_INTERLACE_EN)
- ce_pix  out  1  one-clk pixel enable
- hcount  out  HW  current pixel column, HW = $clog2(H_TOTAL)
- vcount  out  VW  current line, VW = $clog2(V_TOTAL_PAL+1)
- HBlank  out  1  hcount >= H_ACTIVE
- VBlank  out  1  vcount >= active lines of the latched mode
- HSync  out  1  active high
- VSync  out  1  active high
- de  out  1  ~(HBlank | VBlank)
- frame_start  out  1  one-clk pulse at pixel (0,0)
- field  out  1  current interlace field

Behaviour:
- Reset (async assert, sync-free release): div counter = 0, hcount = 0, vcount = 0, latched mode = {pal, scandouble, interlace} sampled while in reset.
- Reset output values: HBlank = 0, VBlank = 0, HSync = 0, VSync = 0, de = 1, ce_pix = 0, frame_start = 0, field = 0.
- Divider: div counts 0..D-1, where D = CE_DIV (or CE_DIV/2 when latched scandouble). ce_pix = 1 on the clk where div == D-1, so the first ce_pix occurs D cycles after reset release.
- Position (hcount, vcount) is the pixel currently presented. On the clk edge ending a ce_pix cycle, the position advances:
  - hcount wraps H_TOTAL-1 -> 0;
  - at that wrap, vcount increments and wraps V_TOTAL-1 -> 0.
- All decodes are registered and computed from the next position, so they are always consistent with hcount/vcount. There is no extra latency.
- HSync = 1 for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- VSync = 1 for vcount in [Vact+V_FP, Vact+V_FP+V_SYNC). It changes only together with vcount, at hcount 0.
- frame_start = ce_pix & (hcount == 0) & (vcount == 0).
- Mode latch:
  - pal, scandouble and interlace are sampled only on the ce_pix cycle at position (H_TOTAL-1, V_TOTAL-1).
  - Changes mid-frame are ignored until then.
  - When scandouble changes, the divider is reset to 0 at that point.
- Counters saturate on nothing. Every wrap is exact; vcount never exceeds V_TOTAL of the latched mode.
- Reset asserted mid-frame: immediate return to reset values. No partial pulses are held.

Optional Feature:
- Macro VTG_INTERLACE_EN.
- Defined, with latched interlace = 1 and scandouble = 0:
  - field toggles at every frame wrap;
  - field 1 frames are one line longer (V_TOTAL+1, e.g. 263 NTSC / 313 PAL);
  - the extra line is blanking, after the back porch.
- Defined, with interlace = 0 or scandouble = 1: field is held at 0.
- Undefined: the interlace input is ignored, field is tied to 0, and the logic is absent.

Decomposition:
- Package vtg_pkg holds:
  - typedef vtg_mode_t, a struct {pal, scandouble, interlace};
  - function vtg_vtotal(mode, field);
  - localparams for the derived H_TOTAL and V_TOTAL values.
- One natural sub-module: vtg_ce_div, the programmable divider with sync clear, producing ce_pix.

Test Plan:
- Reset release, NTSC, scandouble = 0, CE_DIV = 4 -> first ce_pix at clk 4. hcount reaches 399 then wraps to 0. Line period is 1600 clk. Frame is 262 lines = 419200 clk between frame_start pulses.
- HSync window -> rises at hcount 336, falls at 368. HBlank rises at 320. de is low exactly for hcount 320..399 and vcount 240..261.
- Set pal = 1 at vcount 100 -> current frame still wraps at 261. The next frame has VBlank from line 288, VSync on lines 291..293, and wraps at 311.
- scandouble = 1 latched -> ce_pix every 2 clk, line period 800 clk. Counter geometry is unchanged.
- Assert reset_n = 0 at hcount 200 / vcount 50 -> all outputs take reset values asynchronously. After release, the first ce_pix comes 4 clk later at (0,0).
- With VTG_INTERLACE_EN, NTSC, interlace = 1 -> alternating frames of 262 and 263 lines. field is 0 then 1, and frame_start spacing alternates 419200 and 420800 clk.
